// File: rtl/hazard_ctrl_pipe.sv
// hazard_ctrl_pipe: EX/MEM/WB control pipeline with load-use stall,
// BEQ flush and saturating debug counters for stall and flush events.
module hazard_ctrl_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_mem_to_reg,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_beq_instruction,
  input  logic             id_aluSrc,
  input  logic [1:0]       id_aluOp,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             ex_zero,
  output logic             ex_aluSrc_out,
  output logic [1:0]       ex_aluOp_out,
  output logic             mem_mem_read_out,
  output logic             mem_mem_write_out,
  output logic             wb_mem_to_reg_out,
  output logic             wb_reg_write_out,
  output logic [4:0]       wb_rd_out,
  output logic             stall_out,
  output logic             flush_out,
  output logic             pc_src_out,
  output logic [CNT_W-1:0] stall_count_out,
  output logic [CNT_W-1:0] flush_count_out
);

  logic       ex_mem_to_reg;
  logic       ex_reg_write;
  logic       ex_mem_read;
  logic       ex_mem_write;
  logic       ex_beq;
  logic       ex_alu_src;
  logic [1:0] ex_alu_op;
  logic [4:0] ex_rd;

  logic       mem_mem_to_reg;
  logic       mem_reg_write;
  logic       mem_mem_read;
  logic       mem_mem_write;
  logic [4:0] mem_rd;

  logic       wb_mem_to_reg;
  logic       wb_reg_write;
  logic [4:0] wb_rd;

  logic       taken;
  logic       hazard;
  logic       bubble;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Branch resolution and load-use detection from current EX contents
  always_comb begin
    taken  = ex_beq & ex_zero;
    hazard = ex_mem_read & (ex_rd != 5'd0) &
             ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    stall_out  = hazard & ~taken;
    flush_out  = taken;
    pc_src_out = taken;
    bubble     = taken | (hazard & ~taken);
  end

  // EX register: take ID controls, or a bubble on stall or flush
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_beq        <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_rd         <= 5'd0;
    end else if (bubble) begin
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_beq        <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_rd         <= 5'd0;
    end else begin
      ex_mem_to_reg <= id_mem_to_reg;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_beq        <= id_beq_instruction;
      ex_alu_src    <= id_aluSrc;
      ex_alu_op     <= id_aluOp;
      ex_rd         <= id_rd;
    end
  end

  // MEM and WB registers advance every cycle without condition
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_mem_to_reg <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_rd         <= 5'd0;
      wb_mem_to_reg  <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_rd          <= 5'd0;
    end else begin
      mem_mem_to_reg <= ex_mem_to_reg;
      mem_reg_write  <= ex_reg_write;
      mem_mem_read   <= ex_mem_read;
      mem_mem_write  <= ex_mem_write;
      mem_rd         <= ex_rd;
      wb_mem_to_reg  <= mem_mem_to_reg;
      wb_reg_write   <= mem_reg_write;
      wb_rd          <= mem_rd;
    end
  end

  // Saturating stall and flush event counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_out && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_out && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign ex_aluSrc_out     = ex_alu_src;
  assign ex_aluOp_out      = ex_alu_op;
  assign mem_mem_read_out  = mem_mem_read;
  assign mem_mem_write_out = mem_mem_write;
  assign wb_mem_to_reg_out = wb_mem_to_reg;
  assign wb_reg_write_out  = wb_reg_write;
  assign wb_rd_out         = wb_rd;
  assign stall_count_out   = stall_cnt;
  assign flush_count_out   = flush_cnt;

endmodule

// File: doc/hazard_ctrl_pipe.md
# hazard_ctrl_pipe

Carries decoded ID-stage control signals down the EX, MEM and WB pipeline registers of the RISC-V datapath and acts on them. It detects load-use hazards and inserts bubbles. It resolves BEQ in EX and flushes the wrong-path instruction. Its stall and flush outputs drive PC/IF-ID hold and kill, and it keeps saturating counters of both events for debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush event counters

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_beq_instruction, id_aluSrc  input  1 each  control bits of the instruction currently in ID
- id_aluOp  input  2  ALU op class of the ID instruction
- id_rs1, id_rs2, id_rd  input  5 each  register fields of the ID instruction
- ex_zero  input  1  ALU zero flag of the instruction currently in EX
- ex_aluSrc_out  output  1  EX-stage ALU source select
- ex_aluOp_out  output  2  EX-stage ALU op class
- mem_mem_read_out, mem_mem_write_out  output  1 each  MEM-stage memory strobes
- wb_mem_to_reg_out, wb_reg_write_out  output  1 each  WB-stage writeback controls
- wb_rd_out  output  5  WB-stage destination register
- stall_out  output  1  hold PC and IF/ID this cycle (combinational)
- flush_out  output  1  kill IF/ID this cycle (combinational)
- pc_src_out  output  1  select branch target for next PC (combinational)
- stall_count_out, flush_count_out  output  CNT_W each  saturating event counters

## Operation
- Internal pipeline registers: EX holds {mem_to_reg, reg_write, mem_read, mem_write, beq, aluSrc, aluOp, rd}. MEM holds {mem_to_reg, reg_write, mem_read, mem_write, rd}. WB holds {mem_to_reg, reg_write, rd}.
- Every clock, MEM takes the EX fields and WB takes the MEM fields, unconditionally.
- Branch taken: taken = ex_beq & ex_zero. When taken, pc_src_out = 1 and flush_out = 1.
- Load-use hazard: hazard = ex_mem_read & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
- stall_out = hazard & ~taken. A taken branch has priority because the ID instruction is discarded anyway.
- EX register load:
  - If taken or stall_out is asserted, EX loads a bubble: all control bits 0, aluOp 00, rd 0.
  - Otherwise EX loads the id_* inputs.
- A bubble propagates through MEM and WB with no memory or register-file side effects.
- Counters:
  - stall_count increments by 1 in each cycle where stall_out = 1.
  - flush_count increments by 1 in each cycle where flush_out = 1.
  - Both saturate at 2^CNT_W − 1 and never wrap.
- Field mapping: rd = 0 with reg_write = 1 passes through unchanged. The register file ignores x0.

## Timing
- Reset (asynchronous): all pipeline registers and counters clear to 0. As a result every output is 0, including stall_out, flush_out and pc_src_out, which are derived from cleared EX state.
- Reset asserted mid-operation discards in-flight instructions. No partial writeback is allowed.
- Latency from ID to each stage output: EX outputs appear 1 edge after ID, MEM outputs 2 edges, WB outputs 3 edges.
- stall_out, flush_out and pc_src_out are valid in the same cycle as the EX contents that cause them. They are not registered.
- A load-use stall lasts exactly 1 cycle. After the bubble, EX no longer holds the load, so stall_out drops and the held ID instruction enters EX on the next edge.
- Back-to-back taken branches each produce their own 1-cycle flush.
- Hazard and taken in the same cycle: flush_out = 1, stall_out = 0, stall_count is unchanged, and flush_count increments.

## Test plan
- Reset: drive reset high mid-stream with a lw in EX → all outputs 0 immediately, before the next clock edge. After release, the pipeline starts empty.
- Pass-through: R-type in ID (reg_write = 1, aluOp = 10, rd = 5), no hazard → ex_aluOp_out = 10 after 1 edge; wb_reg_write_out = 1 and wb_rd_out = 5 after 3 edges.
- Load-use: lw x3 enters EX (mem_read = 1, rd = 3) while ID has rs1 = 3 → stall_out = 1 for 1 cycle and a bubble enters EX. stall_count_out goes 0→1. The add then enters EX on the following edge.
- Load to x0: lw with rd = 0 in EX and ID rs1 = 0 → stall_out stays 0.
- BEQ taken: beq in EX with ex_zero = 1 → flush_out = 1 and pc_src_out = 1 for 1 cycle. The next EX contents are a bubble and flush_count_out = 1. With ex_zero = 0 there is no flush and no bubble.
- Priority and saturation:
  - Taken branch in EX together with a matching load-use condition → flush only; stall_count is unchanged.
  - With CNT_W = 2, four consecutive flushes → flush_count_out holds at 3.
